// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared widths, enable levels and FSM encoding for the multi-port register file
package regfile_mp_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic READ_ENABLE = 1'b1;
    localparam logic RST_ENABLE = 1'b0;
    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: register file bus (write ports, read ports, scoreboard set, init status); master drives, slave is the register file
interface regfile_mp_if
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    logic [NUM_WR-1:0]        we;
    logic [NUM_WR*ADDR_W-1:0] waddr;
    logic [NUM_WR*DATA_W-1:0] wdata;
    logic [NUM_RD-1:0]        re;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rbusy;
    logic                     sb_set;
    logic [ADDR_W-1:0]        sb_addr;
    logic                     init_done;
    modport master (output we, waddr, wdata, re, raddr, sb_set, sb_addr, input rdata, rbusy, init_done);
    modport slave (input we, waddr, wdata, re, raddr, sb_set, sb_addr, output rdata, rbusy, init_done);
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: busy bit per register (set by decode, cleared by writeback) and per-read-port hazard flags
// Ports: clk, rst (async active-low), we/waddr (writeback), re/raddr (reads), sb_set/sb_addr (decode), rbusy (out)
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr,
    output logic [NUM_RD-1:0]        rbusy
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [DEPTH-1:0] busy, busy_n;
    always_ff @(posedge clk or negedge rst)
        if (rst == RST_ENABLE) busy <= '0;
        else busy <= busy_n;
    // Clears applied first so a same-cycle set on the same address wins (new producer)
    always_comb begin
        busy_n = busy;
        for (int i = 0; i < NUM_WR; i++)
            if (we[i] == WRITE_ENABLE) busy_n[waddr[i*ADDR_W +: ADDR_W]] = 1'b0;
        if (sb_set) busy_n[sb_addr] = 1'b1;
        busy_n[0] = 1'b0;
    end
    for (genvar j = 0; j < NUM_RD; j++) begin : g_rb
        logic [ADDR_W-1:0] ra;
        logic hit;
        assign ra = raddr[j*ADDR_W +: ADDR_W];
        // A writeback landing this cycle resolves the hazard combinationally
        always_comb begin
            hit = 1'b0;
            for (int i = 0; i < NUM_WR; i++)
                if (we[i] == WRITE_ENABLE && waddr[i*ADDR_W +: ADDR_W] == ra) hit = 1'b1;
        end
        assign rbusy[j] = (re[j] == READ_ENABLE) & busy[ra] & ~hit;
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-to-read bypass, busy scoreboard and post-reset zero sweep
// Ports: clk, rst (async active-low), bus (slave: we/waddr/wdata, re/raddr/rdata/rbusy, sb_set/sb_addr, init_done)
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input logic clk,
    input logic rst,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    state_t state, state_n;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] regs [DEPTH];
    logic run;
    logic [NUM_WR-1:0] we_run;
    always_ff @(posedge clk or negedge rst)
        if (rst == RST_ENABLE) begin
            state <= INIT;
            cnt <= '0;
        end else begin
            state <= state_n;
            if (state == INIT) cnt <= cnt + 1'b1;
        end
    always_comb state_n = (state == INIT && &cnt) ? RUN : state;
    assign run = (state == RUN);
    assign bus.init_done = run;
    // Writes and scoreboard sets are ignored until the sweep has finished
    assign we_run = run ? bus.we : '0;
    always_ff @(posedge clk)
        if (!run) regs[cnt] <= '0;
        else
            for (int i = 0; i < NUM_WR; i++)
                if (we_run[i] == WRITE_ENABLE && bus.waddr[i*ADDR_W +: ADDR_W] != '0)
                    regs[bus.waddr[i*ADDR_W +: ADDR_W]] <= bus.wdata[i*DATA_W +: DATA_W];
    // Ascending loops let the youngest (highest-index) writer win in both array and bypass
    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        assign ra = bus.raddr[j*ADDR_W +: ADDR_W];
        always_comb begin
            rd = regs[ra];
            for (int i = 0; i < NUM_WR; i++)
                if (we_run[i] == WRITE_ENABLE && bus.waddr[i*ADDR_W +: ADDR_W] == ra)
                    rd = bus.wdata[i*DATA_W +: DATA_W];
            if (!run || bus.re[j] != READ_ENABLE || ra == '0) rd = '0;
        end
        assign bus.rdata[j*DATA_W +: DATA_W] = rd;
    end
    regfile_scoreboard #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) u_sb (
        .clk(clk),
        .rst(rst),
        .we(we_run),
        .waddr(bus.waddr),
        .re(bus.re),
        .raddr(bus.raddr),
        .sb_set(bus.sb_set & run),
        .sb_addr(bus.sb_addr),
        .rbusy(bus.rbusy)
    );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: table-driven and sequence checks of regfile_mp through an expectation queue
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bus ();
    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { string nm; int sel; logic [31:0] val; } exp_t;
    exp_t q[$];

    typedef struct {
        logic [1:0] we; logic [4:0] wa0, wa1; logic [31:0] wd0, wd1;
        logic [1:0] re; logic [4:0] ra0, ra1; logic sb; logic [4:0] sa;
        logic [31:0] e0, e1; logic [1:0] eb;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0, logic [4:0] wa1, logic [31:0] wd1,
                                logic [1:0] re, logic [4:0] ra0, logic [4:0] ra1, logic sb, logic [4:0] sa,
                                logic [31:0] e0, logic [31:0] e1, logic [1:0] eb);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.re = re; v.ra0 = ra0; v.ra1 = ra1; v.sb = sb; v.sa = sa;
        v.e0 = e0; v.e1 = e1; v.eb = eb;
        return v;
    endfunction

    function automatic logic [31:0] actual(int sel);
        case (sel)
            0: return bus.rdata[31:0];
            1: return bus.rdata[63:32];
            2: return {31'b0, bus.rbusy[0]};
            3: return {31'b0, bus.rbusy[1]};
            default: return {31'b0, bus.init_done};
        endcase
    endfunction

    task automatic expect_val(input string nm, input int sel, input logic [31:0] v);
        exp_t e;
        e.nm = nm; e.sel = sel; e.val = v;
        q.push_back(e);
    endtask

    task automatic check_q();
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (actual(e.sel) !== e.val) begin
                bad++;
                $display("FAIL %s: got %h want %h", e.nm, actual(e.sel), e.val);
            end
        end
    endtask

    task automatic drive(input vec_t v);
        bus.we = v.we; bus.waddr = {v.wa1, v.wa0}; bus.wdata = {v.wd1, v.wd0};
        bus.re = v.re; bus.raddr = {v.ra1, v.ra0}; bus.sb_set = v.sb; bus.sb_addr = v.sa;
    endtask

    task automatic idle();
        drive(mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00));
    endtask

    // Counts rising edges from the release until init_done; inputs stay as driven during the sweep
    task automatic wait_init(input string nm);
        int n;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.init_done) break;
            expect_val({nm, "_sweep_rd0"}, 0, 32'h0);
            expect_val({nm, "_sweep_rd1"}, 1, 32'h0);
            expect_val({nm, "_sweep_rb0"}, 2, 32'h0);
            check_q();
        end
        idle();
        total++;
        if (n != 32) begin
            bad++;
            $display("FAIL %s_latency: got %0d cycles want 32", nm, n);
        end
    endtask

    task automatic run_tbl();
        foreach (tbl[k]) begin
            @(posedge clk);
            #1;
            drive(tbl[k]);
            #3;
            expect_val($sformatf("vec%0d_rd0", k), 0, tbl[k].e0);
            expect_val($sformatf("vec%0d_rd1", k), 1, tbl[k].e1);
            expect_val($sformatf("vec%0d_rb0", k), 2, {31'b0, tbl[k].eb[0]});
            expect_val($sformatf("vec%0d_rb1", k), 3, {31'b0, tbl[k].eb[1]});
            expect_val($sformatf("vec%0d_done", k), 4, 32'h1);
            check_q();
        end
    endtask

    initial begin
        //            we     wa0  wd0           wa1  wd1           re     ra0  ra1  sb  sa    e0            e1            eb
        tbl.push_back(mk(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,       2'b11, 5'd0, 5'd5, 1'b0, 5'd0, 32'h0,       32'hDEADBEEF, 2'b00));
        tbl.push_back(mk(2'b00, 5'd0, 32'h0,       5'd0, 32'h0,       2'b11, 5'd5, 5'd5, 1'b0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00));
        tbl.push_back(mk(2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222, 2'b11, 5'd7, 5'd5, 1'b0, 5'd0, 32'h22222222, 32'hDEADBEEF, 2'b00));
        tbl.push_back(mk(2'b00, 5'd0, 32'h0,       5'd0, 32'h0,       2'b11, 5'd7, 5'd7, 1'b0, 5'd0, 32'h22222222, 32'h22222222, 2'b00));
        tbl.push_back(mk(2'b01, 5'd0, 32'h12345678, 5'd0, 32'h0,       2'b11, 5'd0, 5'd0, 1'b1, 5'd0, 32'h0,       32'h0,       2'b00));
        tbl.push_back(mk(2'b00, 5'd0, 32'h0,       5'd0, 32'h0,       2'b11, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,       32'h0,       2'b00));
        tbl.push_back(mk(2'b00, 5'd0, 32'h0,       5'd0, 32'h0,       2'b11, 5'd9, 5'd9, 1'b1, 5'd9, 32'h0,       32'h0,       2'b00));
        tbl.push_back(mk(2'b00, 5'd0, 32'h0,       5'd0, 32'h0,       2'b01, 5'd9, 5'd9, 1'b0, 5'd0, 32'h0,       32'h0,       2'b01));
        tbl.push_back(mk(2'b10, 5'd0, 32'h0,       5'd9, 32'hA5A5A5A5, 2'b11, 5'd9, 5'd9, 1'b0, 5'd0, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00));
        tbl.push_back(mk(2'b00, 5'd0, 32'h0,       5'd0, 32'h0,       2'b11, 5'd9, 5'd9, 1'b0, 5'd0, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00));
        tbl.push_back(mk(2'b00, 5'd0, 32'h0,       5'd0, 32'h0,       2'b11, 5'd9, 5'd9, 1'b1, 5'd9, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00));
        tbl.push_back(mk(2'b01, 5'd9, 32'h5,       5'd0, 32'h0,       2'b11, 5'd9, 5'd9, 1'b1, 5'd9, 32'h5,       32'h5,       2'b00));
        tbl.push_back(mk(2'b00, 5'd0, 32'h0,       5'd0, 32'h0,       2'b11, 5'd9, 5'd9, 1'b0, 5'd0, 32'h5,       32'h5,       2'b11));
        tbl.push_back(mk(2'b10, 5'd0, 32'h0,       5'd9, 32'h6,       2'b11, 5'd9, 5'd3, 1'b0, 5'd0, 32'h6,       32'h0,       2'b00));
        tbl.push_back(mk(2'b00, 5'd0, 32'h0,       5'd0, 32'h0,       2'b11, 5'd9, 5'd3, 1'b0, 5'd0, 32'h6,       32'h0,       2'b00));
        tbl.push_back(mk(2'b00, 5'd0, 32'h0,       5'd0, 32'h0,       2'b10, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0,       32'hDEADBEEF, 2'b00));
        tbl.push_back(mk(2'b11, 5'd10, 32'h1,      5'd11, 32'h2,      2'b11, 5'd10, 5'd11, 1'b0, 5'd0, 32'h1,      32'h2,       2'b00));
        tbl.push_back(mk(2'b00, 5'd0, 32'h0,       5'd0, 32'h0,       2'b11, 5'd10, 5'd11, 1'b1, 5'd20, 32'h1,     32'h2,       2'b00));
        tbl.push_back(mk(2'b00, 5'd0, 32'h0,       5'd0, 32'h0,       2'b11, 5'd20, 5'd7, 1'b0, 5'd0, 32'h0,       32'h22222222, 2'b01));

        rst = 1'b0;
        drive(mk(2'b11, 5'd3, 32'hFFFF, 5'd4, 32'hFFFF, 2'b11, 5'd3, 5'd4, 1'b1, 5'd3, 32'h0, 32'h0, 2'b00));
        #2;
        expect_val("rst_rd0", 0, 32'h0);
        expect_val("rst_rb0", 2, 32'h0);
        expect_val("rst_done", 4, 32'h0);
        check_q();
        @(negedge clk);
        rst = 1'b1;
        wait_init("init1");

        for (int i = 1; i < 32; i++) begin
            @(posedge clk);
            #1;
            bus.re = 2'b11;
            bus.raddr = {5'(32 - i), 5'(i)};
            #3;
            expect_val($sformatf("zero_r%0d", i), 0, 32'h0);
            expect_val($sformatf("zero_r%0d", 32 - i), 1, 32'h0);
            expect_val($sformatf("nobusy_r%0d", i), 2, 32'h0);
            check_q();
        end

        run_tbl();

        @(posedge clk);
        #1;
        idle();
        bus.re = 2'b11;
        bus.raddr = {5'd7, 5'd20};
        rst = 1'b0;
        #1;
        expect_val("arst_rd0", 0, 32'h0);
        expect_val("arst_rd1", 1, 32'h0);
        expect_val("arst_rb0", 2, 32'h0);
        expect_val("arst_done", 4, 32'h0);
        check_q();
        @(negedge clk);
        rst = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        expect_val("mid_rd1", 1, 32'h0);
        expect_val("mid_done", 4, 32'h0);
        check_q();
        @(negedge clk);
        rst = 1'b1;
        wait_init("init2");

        @(posedge clk);
        #1;
        bus.re = 2'b11;
        bus.raddr = {5'd7, 5'd5};
        #3;
        expect_val("swept_r5", 0, 32'h0);
        expect_val("swept_r7", 1, 32'h0);
        check_q();
        @(posedge clk);
        #1;
        bus.raddr = {5'd9, 5'd20};
        #3;
        expect_val("swept_r9", 1, 32'h0);
        expect_val("busy_clr_r20", 2, 32'h0);
        check_q();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port successor to the single-write, two-read general register file.
- Configurable data width, depth, read-port count and write-port count.
- Adds per-port write-to-read bypass, a register scoreboard (busy bits) for hazard detection, and a post-reset zero-initialisation sweep.
- Sits between the decode stage (reads, scoreboard set) and the writeback stage (writes, scoreboard clear).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- NUM_WR, 2, number of write ports (1..2); a higher index is a younger instruction.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- we  in  NUM_WR  per-port write enable.
- waddr  in  NUM_WR*ADDR_W  write addresses, port i at [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_WR*DATA_W  write data, packed the same way.
- re  in  NUM_RD  per-port read enable.
- raddr  in  NUM_RD*ADDR_W  read addresses, packed.
- rdata  out  NUM_RD*DATA_W  read data, packed.
- rbusy  out  NUM_RD  per read port: the addressed register has a pending producer.
- sb_set  in  1  mark sb_addr busy (decode issues an instruction writing it).
- sb_addr  in  ADDR_W  scoreboard set address.
- init_done  out  1  high once the zero sweep has finished.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=INIT, sweep counter=0, busy vector all 0, init_done=0.
  - While in reset, rdata=0 and rbusy=0.
  - The storage array itself has no reset.
- FSM INIT:
  - Each cycle, write 0 to regs[counter] and increment the counter.
  - When counter = 2**ADDR_W-1, write that entry, set init_done=1 the next cycle and go to RUN.
  - The sweep takes exactly 2**ADDR_W cycles after rst deasserts.
  - we and sb_set are ignored; rdata=0; rbusy=0.
  - Asserting rst mid-sweep restarts the sweep from address 0.
- FSM RUN: init_done stays 1 until the next reset; there is no return to INIT.
- Writes:
  - Port i writes regs[waddr_i] <= wdata_i at the clock edge when we_i=1 and waddr_i != 0.
  - Register 0 is never written and always reads 0.
  - If both ports write the same address in one cycle, port NUM_WR-1 wins.
- Reads (combinational, zero latency). Priority for port j:
  1. raddr_j==0 or re_j==0 -> 0.
  2. Any write port has we=1 and a matching address -> bypass the wdata of the highest-index matching port.
  3. Otherwise -> regs[raddr_j].
- Write latency: data is visible through the array the cycle after the write; it is visible the same cycle through the bypass.
- Scoreboard:
  - busy[a] is set at the edge when sb_set=1 and sb_addr=a != 0.
  - busy[a] is cleared at the edge when any port writes a.
  - Set and clear of the same address in the same cycle -> busy stays 1 (set wins, new producer).
  - busy[0] is always 0.
- rbusy_j = re_j & busy[raddr_j] & ~(same-cycle write to raddr_j). A same-cycle writeback resolves the hazard combinationally.
- Width rules:
  - Addresses are compared over the full ADDR_W bits.
  - No truncation or extension inside the block; all ports are DATA_W.

Decomposition:
- Shared defines/package:
  - DATA_W and ADDR_W defaults, which map onto the existing register-bus and register-address-width macros.
  - The zero word, write/read enable levels, and the RstEnable level (now 1'b0 for this block).
  - FSM state encodings INIT=1'b0, RUN=1'b1.
- One natural sub-module: regfile_scoreboard.
  - Contains the busy vector, the set/clear priority logic and the per-port rbusy generation.
  - Instantiated once, sharing the we/waddr and re/raddr buses.
- The read/bypass mux is a generate loop over NUM_RD, not a sub-module.

Test Plan:
- Release reset with ADDR_W=5 -> init_done rises exactly 32 cycles later. Then reading regs 1..31 gives 0; re/we applied during the sweep have no effect.
- RUN, port0 writes r5=0xDEADBEEF while read port 1 reads r5 in the same cycle -> rdata1=0xDEADBEEF via bypass. Next cycle, with we=0, the read still returns 0xDEADBEEF.
- Both write ports write r7 (0x11111111 on port 0, 0x22222222 on port 1) -> the same-cycle read gives 0x22222222, and the array holds 0x22222222 afterwards.
- Write 0x12345678 to r0 -> a read of r0 gives 0 in the same cycle and the next; busy[0] never sets.
- sb_set r9 -> rbusy=1 when reading r9. Writeback of r9 -> rbusy=0 that same cycle and busy clear the next. A simultaneous sb_set r9 and write r9 -> busy remains 1.
- Pull rst low at sweep address 12 -> rdata=0, init_done=0 immediately. After release, the sweep restarts from 0 and init_done rises 32 cycles later.
